// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-high hex glyphs (segment a at bit 6),
// the blank pattern and the default stability window.
package seg7_pkg;

    localparam int SEG7_STABLE_DEFAULT = 16;

    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Index k holds the glyph for hex digit k.
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Capture-event port of the 7-segment readback block: valid/ready event
// carrying a digit index, plus a sticky overflow flag.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_ready;
    logic             upd_overflow;

    modport master (
        output upd_valid,
        output upd_idx,
        output upd_overflow,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_idx,
        input  upd_overflow,
        output upd_ready
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: active-high 7-bit pattern -> {hit, blank, hex}.
// hit is set only for one of the 16 hex glyphs; blank only for all-off.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] hex
);

    always_comb begin
        hit = 1'b0;
        hex = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (pattern == SEG7_HEX[k]) begin
                hit = 1'b1;
                hex = 4'(k);
            end
        end
    end

    assign blank = (pattern == SEG7_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and reports
// each capture on a valid/ready event port. Define SEG7_DP_CAPTURE_EN to also
// capture the decimal point per digit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = SEG7_STABLE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic                    dp_n,
    input  logic [NUM_DIGITS-1:0]   digs,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   bad_pattern,
    output logic [NUM_DIGITS-1:0]   dp_out,
    seg7_scan_decoder_if.master     upd
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

    logic [6:0]            seg_s1_reg, seg_s2_reg, seg_prev_reg;
    logic [NUM_DIGITS-1:0] digs_s1_reg, digs_s2_reg, digs_prev_reg;
    logic [7:0]            cnt_reg;

    logic [NUM_DIGITS-1:0][3:0] nib_reg;
    logic [NUM_DIGITS-1:0]      valid_reg;
    logic [NUM_DIGITS-1:0]      bad_reg;

    logic             upd_valid_reg;
    logic [IDX_W-1:0] upd_idx_reg;
    logic             upd_overflow_reg;

    logic             sample_changed;
    logic             digs_onehot;
    logic             capture;
    logic             event_fire;
    logic [IDX_W-1:0] cap_idx;
    logic             pat_hit;
    logic             pat_blank;
    logic [3:0]       pat_hex;

`ifdef SEG7_DP_CAPTURE_EN
    logic                  dp_s1_reg, dp_s2_reg, dp_prev_reg;
    logic [NUM_DIGITS-1:0] dp_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_reg    <= '0;
            seg_s2_reg    <= '0;
            seg_prev_reg  <= '0;
            digs_s1_reg   <= '0;
            digs_s2_reg   <= '0;
            digs_prev_reg <= '0;
        end else begin
            seg_s1_reg    <= seg_n;
            seg_s2_reg    <= seg_s1_reg;
            seg_prev_reg  <= seg_s2_reg;
            digs_s1_reg   <= digs;
            digs_s2_reg   <= digs_s1_reg;
            digs_prev_reg <= digs_s2_reg;
        end
    end

    always_comb begin
        sample_changed = (seg_s2_reg != seg_prev_reg) || (digs_s2_reg != digs_prev_reg);
`ifdef SEG7_DP_CAPTURE_EN
        sample_changed = sample_changed || (dp_s2_reg != dp_prev_reg);
`endif
        digs_onehot = ($countones(digs_s2_reg) == 1);
        // Fires once per stable run; the saturated counter blocks re-capture.
        capture    = !sample_changed && digs_onehot && (cnt_reg == CNT_FIRE);
        event_fire = capture && (pat_hit || pat_blank);
        cap_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digs_s2_reg[i]) begin
                cap_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (sample_changed || !digs_onehot) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (~seg_s2_reg),
        .hit     (pat_hit),
        .blank   (pat_blank),
        .hex     (pat_hex)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_reg   <= '0;
            valid_reg <= '0;
            bad_reg   <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digs_s2_reg[i]) begin
                    if (pat_hit) begin
                        nib_reg[i]   <= pat_hex;
                        valid_reg[i] <= 1'b1;
                        bad_reg[i]   <= 1'b0;
                    end else if (pat_blank) begin
                        valid_reg[i] <= 1'b0;
                        bad_reg[i]   <= 1'b0;
                    end else begin
                        bad_reg[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    // A new event always wins; overflow only when the pending one was not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_reg    <= 1'b0;
            upd_idx_reg      <= '0;
            upd_overflow_reg <= 1'b0;
        end else if (event_fire) begin
            upd_valid_reg <= 1'b1;
            upd_idx_reg   <= cap_idx;
            if (upd_valid_reg && !upd.upd_ready) begin
                upd_overflow_reg <= 1'b1;
            end
        end else if (upd_valid_reg && upd.upd_ready) begin
            upd_valid_reg <= 1'b0;
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_s1_reg   <= 1'b0;
            dp_s2_reg   <= 1'b0;
            dp_prev_reg <= 1'b0;
            dp_reg      <= '0;
        end else begin
            dp_s1_reg   <= dp_n;
            dp_s2_reg   <= dp_s1_reg;
            dp_prev_reg <= dp_s2_reg;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && digs_s2_reg[i]) begin
                    dp_reg[i] <= ~dp_s2_reg;
                end
            end
        end
    end
    assign dp_out = dp_reg;
`else
    logic unused_dp_n;
    assign unused_dp_n = dp_n;
    assign dp_out      = '0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_out
        assign hex_out[gi*4 +: 4] = nib_reg[gi];
    end

    assign digit_valid      = valid_reg;
    assign bad_pattern      = bad_reg;
    assign upd.upd_valid    = upd_valid_reg;
    assign upd.upd_idx      = upd_idx_reg;
    assign upd.upd_overflow = upd_overflow_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=16).
// Honours SEG7_DP_CAPTURE_EN when choosing the expected dp_out value.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  digs;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_pattern;
    logic [3:0]  dp_out;
    logic [3:0]  exp_dp;

    int vectors     = 0;
    int miscompares = 0;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) upd_if ();

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .digs        (digs),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .bad_pattern (bad_pattern),
        .dp_out      (dp_out),
        .upd         (upd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".hex_out"},     32'(hex_out),             32'h0);
        check({tag, ".digit_valid"}, 32'(digit_valid),         32'h0);
        check({tag, ".bad_pattern"}, 32'(bad_pattern),         32'h0);
        check({tag, ".dp_out"},      32'(dp_out),              32'h0);
        check({tag, ".upd_valid"},   32'(upd_if.upd_valid),    32'h0);
        check({tag, ".upd_idx"},     32'(upd_if.upd_idx),      32'h0);
        check({tag, ".upd_overflow"},32'(upd_if.upd_overflow), 32'h0);
    endtask

    initial begin
`ifdef SEG7_DP_CAPTURE_EN
        exp_dp = 4'b1000;
`else
        exp_dp = 4'b0000;
`endif
        rst_n            = 1'b0;
        seg_n            = 7'h7F;
        dp_n             = 1'b1;
        digs             = 4'b0000;
        upd_if.upd_ready = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(1);

        // Static "0" on digit 0: nothing at edge 17, capture at edge 18.
        digs  = 4'b0001;
        seg_n = 7'h01;
        tick(18);
        check("static.edge17_valid", 32'(upd_if.upd_valid), 32'h0);
        tick(1);
        check("static.valid",       32'(upd_if.upd_valid), 32'h1);
        check("static.idx",         32'(upd_if.upd_idx),   32'h0);
        check("static.hex",         32'(hex_out),          32'h0);
        check("static.digit_valid", 32'(digit_valid),      32'h1);
        upd_if.upd_ready = 1'b1;
        tick(1);
        check("static.accepted", 32'(upd_if.upd_valid), 32'h0);

        // Scan "1","2","3","4" onto digits 0..3.
        digs = 4'b0001; seg_n = 7'h4F;
        tick(19);
        check("scan0.valid", 32'(upd_if.upd_valid), 32'h1);
        check("scan0.idx",   32'(upd_if.upd_idx),   32'h0);
        tick(13);
        digs = 4'b0010; seg_n = 7'h12;
        tick(19);
        check("scan1.valid", 32'(upd_if.upd_valid), 32'h1);
        check("scan1.idx",   32'(upd_if.upd_idx),   32'h1);
        tick(13);
        digs = 4'b0100; seg_n = 7'h06;
        tick(19);
        check("scan2.valid", 32'(upd_if.upd_valid), 32'h1);
        check("scan2.idx",   32'(upd_if.upd_idx),   32'h2);
        tick(13);
        digs = 4'b1000; seg_n = 7'h4C;
        tick(19);
        check("scan3.valid", 32'(upd_if.upd_valid), 32'h1);
        check("scan3.idx",   32'(upd_if.upd_idx),   32'h3);
        tick(13);
        check("scan.hex",         32'(hex_out),          32'h4321);
        check("scan.digit_valid", 32'(digit_valid),      32'hF);
        check("scan.valid_idle",  32'(upd_if.upd_valid), 32'h0);

        // Glitches with ready low, so any stray capture would stay visible.
        upd_if.upd_ready = 1'b0;
        digs = 4'b0001; seg_n = 7'h24;
        tick(10);
        check("glitch.short_hex", 32'(hex_out), 32'h4321);
        digs = 4'b0011;
        tick(40);
        check("glitch.twohot_valid", 32'(upd_if.upd_valid), 32'h0);
        check("glitch.twohot_hex",   32'(hex_out),          32'h4321);
        digs = 4'b0000;
        tick(40);
        check("glitch.nohot_valid", 32'(upd_if.upd_valid),    32'h0);
        check("glitch.nohot_hex",   32'(hex_out),             32'h4321);
        check("glitch.dv",          32'(digit_valid),         32'hF);
        check("glitch.overflow",    32'(upd_if.upd_overflow), 32'h0);

        // Bad glyph (only g lit) then blank on digit 2.
        upd_if.upd_ready = 1'b1;
        digs = 4'b0100; seg_n = 7'h7E;
        tick(19);
        check("bad.bad_pattern", 32'(bad_pattern),      32'h4);
        check("bad.hex",         32'(hex_out),          32'h4321);
        check("bad.digit_valid", 32'(digit_valid),      32'hF);
        check("bad.no_event",    32'(upd_if.upd_valid), 32'h0);
        seg_n = 7'h7F;
        tick(19);
        check("blank.digit_valid", 32'(digit_valid),      32'hB);
        check("blank.bad_pattern", 32'(bad_pattern),      32'h0);
        check("blank.hex",         32'(hex_out),          32'h4321);
        check("blank.valid",       32'(upd_if.upd_valid), 32'h1);
        check("blank.idx",         32'(upd_if.upd_idx),   32'h2);
        tick(1);

        // Decimal point on digit 3.
        digs = 4'b1000; seg_n = 7'h4C; dp_n = 1'b0;
        tick(19);
        check("dp.dp_out", 32'(dp_out),          32'(exp_dp));
        check("dp.valid",  32'(upd_if.upd_valid), 32'h1);
        check("dp.idx",    32'(upd_if.upd_idx),   32'h3);
        tick(1);
        dp_n = 1'b1;

        // Two captures with ready low: second overwrites and sets overflow.
        upd_if.upd_ready = 1'b0;
        digs = 4'b0001; seg_n = 7'h06;
        tick(19);
        check("hs.first_valid",    32'(upd_if.upd_valid),    32'h1);
        check("hs.first_idx",      32'(upd_if.upd_idx),      32'h0);
        check("hs.first_overflow", 32'(upd_if.upd_overflow), 32'h0);
        digs = 4'b0010; seg_n = 7'h0F;
        tick(19);
        check("hs.second_valid", 32'(upd_if.upd_valid),    32'h1);
        check("hs.second_idx",   32'(upd_if.upd_idx),      32'h1);
        check("hs.overflow",     32'(upd_if.upd_overflow), 32'h1);
        check("hs.hex",          32'(hex_out),             32'h4373);
        check("hs.digit_valid",  32'(digit_valid),         32'hB);

        // Asynchronous reset mid-count, then a full-latency capture.
        digs = 4'b0100; seg_n = 7'h00;
        tick(8);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        #1;
        rst_n = 1'b1;
        tick(18);
        check("postreset.edge17_valid", 32'(upd_if.upd_valid), 32'h0);
        tick(1);
        check("postreset.valid",       32'(upd_if.upd_valid),    32'h1);
        check("postreset.idx",         32'(upd_if.upd_idx),      32'h2);
        check("postreset.hex",         32'(hex_out),             32'h0800);
        check("postreset.digit_valid", 32'(digit_valid),         32'h4);
        check("postreset.overflow",    32'(upd_if.upd_overflow), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
